// File: rtl/decode_bypass_rf.sv
// rtl/decode_bypass_rf.sv - MIPS decode stage: register file, per-operand bypass, load-use interlock.
// Drives the ID/EX slot and counts the bubbles inserted by the interlock.
module decode_bypass_rf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_stall_c,
  input  logic              mem_stall_c,
  input  logic              if_id_valid,
  input  logic [ADDR_W-1:0] if_id_nextpc,
  input  logic [31:0]       if_id_ir,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_is_load,
  input  logic [4:0]        ex_mem_dest,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic              mem_wb_valid,
  input  logic [4:0]        mem_wb_dest,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic              id_ex_valid,
  output logic [ADDR_W-1:0] id_ex_nextpc,
  output logic [DATA_W-1:0] id_ex_a,
  output logic [DATA_W-1:0] id_ex_b,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [4:0]        id_ex_rd,
  output logic [4:0]        id_ex_rt,
  output logic [5:0]        id_ex_op,
  output logic              id_stall_c,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam int RI = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] rf_q [NREGS];

  logic [RI-1:0] rs_idx, rt_idx, exm_idx, mwb_idx, wb_idx;
  logic          rs_zero, rt_zero, exm_zero, wb_zero;
  logic [5:0]    opcode, funct;
  logic signed [15:0] imm_s;

  assign opcode  = if_id_ir[31:26];
  assign funct   = if_id_ir[5:0];
  assign imm_s   = if_id_ir[15:0];
  assign rs_idx  = if_id_ir[21 +: RI];
  assign rt_idx  = if_id_ir[16 +: RI];
  assign exm_idx = ex_mem_dest[RI-1:0];
  assign mwb_idx = mem_wb_dest[RI-1:0];
  assign wb_idx  = wb_dest[RI-1:0];

  assign rs_zero  = ZERO_REG && (rs_idx == '0);
  assign rt_zero  = ZERO_REG && (rt_idx == '0);
  assign exm_zero = ZERO_REG && (exm_idx == '0);
  assign wb_zero  = ZERO_REG && (wb_idx == '0);

  // Operand bypass: youngest producer wins; loads in EX/MEM have no data yet
  logic [DATA_W-1:0] op_a, op_b;

  always_comb begin
    op_a = rf_q[rs_idx];
    if (rs_zero)
      op_a = '0;
    else if (ex_mem_valid && !ex_mem_is_load && (exm_idx == rs_idx))
      op_a = ex_mem_result;
    else if (mem_wb_valid && (mwb_idx == rs_idx))
      op_a = mem_wb_data;
    else if (wb_we && (wb_idx == rs_idx))
      op_a = wb_value;
  end

  always_comb begin
    op_b = rf_q[rt_idx];
    if (rt_zero)
      op_b = '0;
    else if (ex_mem_valid && !ex_mem_is_load && (exm_idx == rt_idx))
      op_b = ex_mem_result;
    else if (mem_wb_valid && (mwb_idx == rt_idx))
      op_b = mem_wb_data;
    else if (wb_we && (wb_idx == rt_idx))
      op_b = wb_value;
  end

  logic load_use, down_stall;

  assign down_stall = ex_stall_c | mem_stall_c;
  assign load_use   = if_id_valid && ex_mem_valid && ex_mem_is_load && !exm_zero &&
                      ((exm_idx == rs_idx) || (exm_idx == rt_idx));
  assign id_stall_c = down_stall | load_use;

  // Register file: write-back lands regardless of stalls or bubbles
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we && !wb_zero) begin
      rf_q[wb_idx] <= wb_value;
    end
  end

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] nextpc_q, nextpc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [4:0]        rd_q, rd_d, rt_q, rt_d;
  logic [5:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    valid_d  = valid_q;
    nextpc_d = nextpc_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    rt_d     = rt_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    if (!down_stall) begin
      if (load_use) begin
        valid_d = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        valid_d  = if_id_valid;
        nextpc_d = if_id_nextpc;
        a_d      = op_a;
        b_d      = op_b;
        imm_d    = DATA_W'(imm_s);
        rd_d     = if_id_ir[15:11];
        rt_d     = if_id_ir[20:16];
        op_d     = (opcode == 6'd0) ? funct : opcode;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      nextpc_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      rt_q     <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      nextpc_q <= nextpc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      rt_q     <= rt_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  assign id_ex_valid  = valid_q;
  assign id_ex_nextpc = nextpc_q;
  assign id_ex_a      = a_q;
  assign id_ex_b      = b_q;
  assign id_ex_imm    = imm_q;
  assign id_ex_rd     = rd_q;
  assign id_ex_rt     = rt_q;
  assign id_ex_op     = op_q;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_bypass_rf.sv
// tb/tb_decode_bypass_rf.sv - scoreboard bench for decode_bypass_rf.
module tb_decode_bypass_rf;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_stall_c, mem_stall_c, if_id_valid;
  logic [31:0] if_id_nextpc, if_id_ir;
  logic        ex_mem_valid, ex_mem_is_load;
  logic [4:0]  ex_mem_dest, mem_wb_dest, wb_dest;
  logic [31:0] ex_mem_result, mem_wb_data, wb_value;
  logic        mem_wb_valid, wb_we;
  logic        id_ex_valid, id_stall_c;
  logic [31:0] id_ex_nextpc, id_ex_a, id_ex_b, id_ex_imm;
  logic [4:0]  id_ex_rd, id_ex_rt;
  logic [5:0]  id_ex_op;
  logic [15:0] bubble_cnt;

  decode_bypass_rf dut (
    .clock(clock), .reset_n(reset_n),
    .ex_stall_c(ex_stall_c), .mem_stall_c(mem_stall_c),
    .if_id_valid(if_id_valid), .if_id_nextpc(if_id_nextpc), .if_id_ir(if_id_ir),
    .ex_mem_valid(ex_mem_valid), .ex_mem_is_load(ex_mem_is_load),
    .ex_mem_dest(ex_mem_dest), .ex_mem_result(ex_mem_result),
    .mem_wb_valid(mem_wb_valid), .mem_wb_dest(mem_wb_dest), .mem_wb_data(mem_wb_data),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_value(wb_value),
    .id_ex_valid(id_ex_valid), .id_ex_nextpc(id_ex_nextpc),
    .id_ex_a(id_ex_a), .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm),
    .id_ex_rd(id_ex_rd), .id_ex_rt(id_ex_rt), .id_ex_op(id_ex_op),
    .id_stall_c(id_stall_c), .bubble_cnt(bubble_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [31:0] nextpc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [5:0]  op;
    logic [15:0] cnt;
  } slot_t;

  typedef struct {
    string name;
    slot_t exp;
  } sb_t;

  sb_t   sb[$];
  slot_t last;
  int    passed = 0;
  int    total = 0;
  int    cnt_exp = 0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic slot_t make_exp(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                                     input logic [31:0] a, input logic [31:0] b);
    slot_t e;
    e.valid  = v;
    e.nextpc = pc;
    e.a      = a;
    e.b      = b;
    e.imm    = {{16{ir[15]}}, ir[15:0]};
    e.rd     = ir[15:11];
    e.rt     = ir[20:16];
    e.op     = (ir[31:26] == 6'd0) ? ir[5:0] : ir[31:26];
    e.cnt    = cnt_exp[15:0];
    return e;
  endfunction

  function automatic slot_t observe();
    slot_t o;
    o = {id_ex_valid, id_ex_nextpc, id_ex_a, id_ex_b, id_ex_imm,
         id_ex_rd, id_ex_rt, id_ex_op, bubble_cnt};
    return o;
  endfunction

  task automatic push(input string n, input slot_t e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    sb.push_back(s);
    last = e;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    ex_stall_c = 0; mem_stall_c = 0; if_id_valid = 0; if_id_nextpc = 0; if_id_ir = 0;
    ex_mem_valid = 0; ex_mem_is_load = 0; ex_mem_dest = 0; ex_mem_result = 0;
    mem_wb_valid = 0; mem_wb_dest = 0; mem_wb_data = 0;
    wb_we = 0; wb_dest = 0; wb_value = 0;
  endtask

  task automatic test_reset();
    sb_t s;
    slot_t got;
    clear_inputs();
    reset_n = 0;
    cnt_exp = 0;
    push("reset_state", '0);
    tick();
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    total++;
    if (id_stall_c !== 1'b0) $display("FAIL reset_stall: got %b expected 0", id_stall_c);
    else passed++;
    reset_n = 1;
  endtask

  task automatic test_rf_write();
    sb_t s;
    slot_t got;
    logic [31:0] ir;
    wb_we = 1; wb_dest = 5; wb_value = 32'h1234;
    tick();
    wb_we = 0;
    tick();
    ir = r_ins(5, 5, 7, 6'h20);
    if_id_valid = 1; if_id_nextpc = 32'h104; if_id_ir = ir;
    push("rf_read_add", make_exp(1, 32'h104, ir, 32'h1234, 32'h1234));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
  endtask

  task automatic test_priority();
    sb_t s;
    slot_t got;
    logic [31:0] ir;
    ir = r_ins(3, 3, 8, 6'h21);
    if_id_valid = 1; if_id_nextpc = 32'h108; if_id_ir = ir;
    ex_mem_valid = 1; ex_mem_is_load = 0; ex_mem_dest = 3; ex_mem_result = 32'hA;
    mem_wb_valid = 1; mem_wb_dest = 3; mem_wb_data = 32'hB;
    wb_we = 1; wb_dest = 3; wb_value = 32'hC;
    for (int step = 0; step < 4; step++) begin
      case (step)
        0: push("prio_exmem", make_exp(1, 32'h108, ir, 32'hA, 32'hA));
        1: begin ex_mem_valid = 0; push("prio_memwb", make_exp(1, 32'h108, ir, 32'hB, 32'hB)); end
        2: begin mem_wb_valid = 0; push("prio_wb", make_exp(1, 32'h108, ir, 32'hC, 32'hC)); end
        default: begin wb_we = 0; push("prio_rf", make_exp(1, 32'h108, ir, 32'hC, 32'hC)); end
      endcase
      tick();
      s = sb.pop_front(); got = observe(); total++;
      if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      else passed++;
    end
  endtask

  task automatic test_split();
    sb_t s;
    slot_t got;
    logic [31:0] ir;
    ir = i_ins(6'h08, 1, 2, 16'h8001);
    if_id_valid = 1; if_id_nextpc = 32'h10C; if_id_ir = ir;
    ex_mem_valid = 1; ex_mem_is_load = 0; ex_mem_dest = 1; ex_mem_result = 32'h11;
    wb_we = 1; wb_dest = 2; wb_value = 32'h22;
    push("split_fwd", make_exp(1, 32'h10C, ir, 32'h11, 32'h22));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    ex_mem_valid = 0; wb_we = 0;
  endtask

  task automatic test_load_use();
    sb_t s;
    slot_t got, e;
    logic [31:0] ir;
    ir = r_ins(4, 6, 9, 6'h20);
    if_id_valid = 1; if_id_nextpc = 32'h200; if_id_ir = ir;
    ex_mem_valid = 1; ex_mem_is_load = 1; ex_mem_dest = 4; ex_mem_result = 32'h99;
    #1;
    total++;
    if (id_stall_c !== 1'b1) $display("FAIL load_use_stall: got %b expected 1", id_stall_c);
    else passed++;
    cnt_exp++;
    e = last; e.valid = 0; e.cnt = cnt_exp[15:0];
    push("load_use_bubble", e);
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    ex_mem_valid = 0; ex_mem_is_load = 0;
    mem_wb_valid = 1; mem_wb_dest = 4; mem_wb_data = 32'h55;
    #1;
    total++;
    if (id_stall_c !== 1'b0) $display("FAIL load_use_release: got %b expected 0", id_stall_c);
    else passed++;
    push("load_use_memwb_fwd", make_exp(1, 32'h200, ir, 32'h55, 32'h0));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    mem_wb_valid = 0;
    // rt-only match stalls; an empty IF/ID slot does not
    if_id_ir = r_ins(1, 6, 9, 6'h20);
    ex_mem_valid = 1; ex_mem_is_load = 1; ex_mem_dest = 6;
    #1;
    total++;
    if (id_stall_c !== 1'b1) $display("FAIL load_use_rt: got %b expected 1", id_stall_c);
    else passed++;
    if_id_valid = 0;
    #1;
    total++;
    if (id_stall_c !== 1'b0) $display("FAIL load_use_no_ifid: got %b expected 0", id_stall_c);
    else passed++;
    ex_mem_valid = 0; ex_mem_is_load = 0;
  endtask

  task automatic test_zero_reg();
    sb_t s;
    slot_t got;
    logic [31:0] ir;
    ir = r_ins(0, 0, 10, 6'h25);
    if_id_valid = 1; if_id_nextpc = 32'h210; if_id_ir = ir;
    ex_mem_valid = 1; ex_mem_is_load = 1; ex_mem_dest = 0; ex_mem_result = 32'h77;
    mem_wb_valid = 1; mem_wb_dest = 0; mem_wb_data = 32'h66;
    wb_we = 1; wb_dest = 0; wb_value = 32'hFF;
    #1;
    total++;
    if (id_stall_c !== 1'b0) $display("FAIL zero_no_stall: got %b expected 0", id_stall_c);
    else passed++;
    push("zero_fwd_blocked", make_exp(1, 32'h210, ir, 32'h0, 32'h0));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    ex_mem_valid = 0; ex_mem_is_load = 0; mem_wb_valid = 0; wb_we = 0;
    push("zero_rf_read", make_exp(1, 32'h210, ir, 32'h0, 32'h0));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
  endtask

  task automatic test_stall_reset();
    sb_t s;
    slot_t got;
    logic [31:0] ir;
    ir = i_ins(6'h0D, 0, 11, 16'h0042);
    if_id_valid = 1; if_id_nextpc = 32'h300; if_id_ir = ir;
    push("pre_stall_decode", make_exp(1, 32'h300, ir, 32'h0, 32'h0));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    ex_stall_c = 1;
    ex_mem_valid = 1; ex_mem_is_load = 1; ex_mem_dest = 9;
    if_id_nextpc = 32'h304; if_id_ir = r_ins(9, 9, 12, 6'h20);
    wb_we = 1; wb_dest = 10; wb_value = 32'hABCD;
    #1;
    total++;
    if (id_stall_c !== 1'b1) $display("FAIL stall_comb: got %b expected 1", id_stall_c);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      push($sformatf("stall_hold_%0d", c), last);
      tick();
      s = sb.pop_front(); got = observe(); total++;
      if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      else passed++;
    end
    ex_stall_c = 0; ex_mem_valid = 0; ex_mem_is_load = 0; wb_we = 0;
    ir = r_ins(10, 0, 12, 6'h22);
    if_id_nextpc = 32'h308; if_id_ir = ir;
    push("wb_during_stall", make_exp(1, 32'h308, ir, 32'hABCD, 32'h0));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    ex_stall_c = 1; ex_mem_valid = 1; ex_mem_is_load = 1; ex_mem_dest = 10;
    reset_n = 0;
    cnt_exp = 0;
    push("reset_mid_stall", '0);
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
    reset_n = 1;
    ex_stall_c = 0; ex_mem_valid = 0; ex_mem_is_load = 0;
    push("rf_cleared", make_exp(1, 32'h308, ir, 32'h0, 32'h0));
    tick();
    s = sb.pop_front(); got = observe(); total++;
    if (got !== s.exp) $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rf_write();
    test_priority();
    test_split();
    test_load_use();
    test_zero_reg();
    test_stall_reset();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
